// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch (I) and data access (D), one transaction at a time.
// Build option MEMARB_ROUND_ROBIN_EN: round-robin on contention; otherwise D always beats I.
module mem_port_arbiter #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    i_req_valid,
   output logic                    i_req_ready,
   input  logic [ADDR_WIDTH-1:0]   i_req_addr,
   output logic                    i_resp_valid,
   output logic [DATA_WIDTH-1:0]   i_resp_rdata,
   input  logic                    d_req_valid,
   output logic                    d_req_ready,
   input  logic [ADDR_WIDTH-1:0]   d_req_addr,
   input  logic                    d_req_wen,
   input  logic [DATA_WIDTH-1:0]   d_req_wdata,
   input  logic [DATA_WIDTH/8-1:0] d_req_wmask,
   output logic                    d_resp_valid,
   output logic [DATA_WIDTH-1:0]   d_resp_rdata,
   output logic                    mem_req_valid,
   input  logic                    mem_req_ready,
   output logic [ADDR_WIDTH-1:0]   mem_req_addr,
   output logic                    mem_req_wen,
   output logic [DATA_WIDTH-1:0]   mem_req_wdata,
   output logic [DATA_WIDTH/8-1:0] mem_req_wmask,
   input  logic                    mem_resp_valid,
   input  logic [DATA_WIDTH-1:0]   mem_resp_rdata
);
   localparam int MASK_WIDTH = DATA_WIDTH / 8;
   localparam logic PORT_I = 1'b0;
   localparam logic PORT_D = 1'b1;

   typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, RESP = 2'd2} state_t;

   state_t                  state_r, state_s;
   logic                    owner_r;
   logic                    grant_i_s, grant_d_s;
   logic [ADDR_WIDTH-1:0]   addr_r;
   logic                    wen_r;
   logic [DATA_WIDTH-1:0]   wdata_r;
   logic [MASK_WIDTH-1:0]   wmask_r;
   logic                    i_resp_valid_r, d_resp_valid_r;
   logic [DATA_WIDTH-1:0]   i_rdata_r, d_rdata_r;
`ifdef MEMARB_ROUND_ROBIN_EN
   logic                    last_grant_r;
`endif

   // Arbitration: only an IDLE arbiter grants, and at most one port at a time
   always_comb begin
      grant_i_s = 1'b0;
      grant_d_s = 1'b0;
      if (state_r == IDLE) begin
`ifdef MEMARB_ROUND_ROBIN_EN
         if (i_req_valid && d_req_valid) begin
            grant_d_s = (last_grant_r == PORT_I);
            grant_i_s = (last_grant_r == PORT_D);
         end else begin
            grant_d_s = d_req_valid;
            grant_i_s = i_req_valid;
         end
`else
         grant_d_s = d_req_valid;
         grant_i_s = i_req_valid & ~d_req_valid;
`endif
      end else begin
         grant_i_s = 1'b0;
         grant_d_s = 1'b0;
      end
   end

   // Next-state logic
   always_comb begin
      state_s = state_r;
      case (state_r)
         IDLE: begin
            if (grant_i_s || grant_d_s) state_s = REQ;
            else                        state_s = IDLE;
         end
         REQ: begin
            if (mem_req_ready) state_s = RESP;
            else               state_s = REQ;
         end
         RESP: begin
            if (mem_resp_valid) state_s = IDLE;
            else                state_s = RESP;
         end
         default: state_s = IDLE;
      endcase
   end

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_r <= IDLE;
      else     state_r <= state_s;
   end

   // Payload capture on grant and response routing back to the owner
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         owner_r        <= PORT_I;
         addr_r         <= {ADDR_WIDTH{1'b0}};
         wen_r          <= 1'b0;
         wdata_r        <= {DATA_WIDTH{1'b0}};
         wmask_r        <= {MASK_WIDTH{1'b0}};
         i_resp_valid_r <= 1'b0;
         d_resp_valid_r <= 1'b0;
         i_rdata_r      <= {DATA_WIDTH{1'b0}};
         d_rdata_r      <= {DATA_WIDTH{1'b0}};
      end else begin
         i_resp_valid_r <= 1'b0;
         d_resp_valid_r <= 1'b0;
         case (state_r)
            IDLE: begin
               if (grant_d_s) begin
                  owner_r <= PORT_D;
                  addr_r  <= d_req_addr;
                  wen_r   <= d_req_wen;
                  wdata_r <= d_req_wdata;
                  wmask_r <= d_req_wmask;
               end else if (grant_i_s) begin
                  owner_r <= PORT_I;
                  addr_r  <= i_req_addr;
                  wen_r   <= 1'b0;
                  wdata_r <= {DATA_WIDTH{1'b0}};
                  wmask_r <= {MASK_WIDTH{1'b0}};
               end
            end
            RESP: begin
               if (mem_resp_valid) begin
                  if (owner_r == PORT_D) begin
                     d_resp_valid_r <= 1'b1;
                     d_rdata_r      <= mem_resp_rdata;
                  end else begin
                     i_resp_valid_r <= 1'b1;
                     i_rdata_r      <= mem_resp_rdata;
                  end
               end
            end
            default: ;
         endcase
      end
   end

`ifdef MEMARB_ROUND_ROBIN_EN
   // Every grant, contended or not, moves the round-robin pointer
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                          last_grant_r <= PORT_I;
      else if (grant_d_s)               last_grant_r <= PORT_D;
      else if (grant_i_s)               last_grant_r <= PORT_I;
      else                              last_grant_r <= last_grant_r;
   end
`endif

   assign i_req_ready   = grant_i_s;
   assign d_req_ready   = grant_d_s;
   assign mem_req_valid = (state_r == REQ);
   assign mem_req_addr  = addr_r;
   assign mem_req_wen   = wen_r;
   assign mem_req_wdata = wdata_r;
   assign mem_req_wmask = wmask_r;
   assign i_resp_valid  = i_resp_valid_r;
   assign i_resp_rdata  = i_rdata_r;
   assign d_resp_valid  = d_resp_valid_r;
   assign d_resp_rdata  = d_rdata_r;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: expected responses queued at acceptance, checked at the pulse.
module tb_mem_port_arbiter;
   localparam logic [31:0] K = 32'hA5A5_0000;

   logic        clk = 1'b0;
   logic        rst;
   logic        i_req_valid, i_req_ready, i_resp_valid;
   logic [31:0] i_req_addr, i_resp_rdata;
   logic        d_req_valid, d_req_ready, d_req_wen, d_resp_valid;
   logic [31:0] d_req_addr, d_req_wdata, d_resp_rdata;
   logic [3:0]  d_req_wmask;
   logic        mem_req_valid, mem_req_ready, mem_req_wen, mem_resp_valid;
   logic [31:0] mem_req_addr, mem_req_wdata, mem_resp_rdata;
   logic [3:0]  mem_req_wmask;

   int pass_cnt = 0;
   int chk_cnt  = 0;
   bit          exp_port_q[$];
   logic [31:0] exp_data_q[$];
   logic [31:0] hold_i, hold_d;
   logic        resp_due, mem_ready_en;
   logic [31:0] resp_due_data;

   always #5 clk = ~clk;

   mem_port_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
      .clk(clk), .rst(rst),
      .i_req_valid(i_req_valid), .i_req_ready(i_req_ready), .i_req_addr(i_req_addr),
      .i_resp_valid(i_resp_valid), .i_resp_rdata(i_resp_rdata),
      .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_req_addr(d_req_addr),
      .d_req_wen(d_req_wen), .d_req_wdata(d_req_wdata), .d_req_wmask(d_req_wmask),
      .d_resp_valid(d_resp_valid), .d_resp_rdata(d_resp_rdata),
      .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
      .mem_req_wen(mem_req_wen), .mem_req_wdata(mem_req_wdata), .mem_req_wmask(mem_req_wmask),
      .mem_resp_valid(mem_resp_valid), .mem_resp_rdata(mem_resp_rdata)
   );

   // Memory model: drive the response owed from the previous handshake
   task automatic mem_pre();
      mem_resp_valid = resp_due;
      if (resp_due) mem_resp_rdata = resp_due_data;
      resp_due = 1'b0;
   endtask

   // Memory model: accept a pending request, owing addr^K next cycle
   task automatic mem_post();
      if (mem_req_valid === 1'b1 && mem_ready_en) begin
         mem_req_ready = 1'b1;
         resp_due      = 1'b1;
         resp_due_data = mem_req_addr ^ K;
      end else begin
         mem_req_ready = 1'b0;
      end
   endtask

   task automatic apply_reset();
      rst = 1'b1;
      i_req_valid = 1'b0; d_req_valid = 1'b0; mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
      resp_due = 1'b0; hold_i = 32'h0; hold_d = 32'h0;
      exp_port_q.delete(); exp_data_q.delete();
      @(negedge clk); @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      @(negedge clk); @(negedge clk); #1;
      chk_cnt++;
      if ({i_req_ready, d_req_ready, i_resp_valid, d_resp_valid, mem_req_valid, mem_req_wen} !== 6'b0 ||
          i_resp_rdata !== 32'h0 || d_resp_rdata !== 32'h0 || mem_req_addr !== 32'h0 ||
          mem_req_wdata !== 32'h0 || mem_req_wmask !== 4'h0)
         $display("FAIL reset_state: got flags=%b addr=%h", {i_req_ready, d_req_ready, i_resp_valid, d_resp_valid, mem_req_valid}, mem_req_addr);
      else pass_cnt++;
      rst = 1'b0;
      @(negedge clk); i_req_valid = 1'b1; i_req_addr = 32'h0000_0040; #1;
      chk_cnt++;
      if (i_req_ready !== 1'b1) $display("FAIL accept_before_rst: got %b expected 1", i_req_ready); else pass_cnt++;
      @(negedge clk); i_req_valid = 1'b0; #1;
      chk_cnt++;
      if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h40)
         $display("FAIL req_before_rst: got valid=%b addr=%h expected 1/00000040", mem_req_valid, mem_req_addr);
      else pass_cnt++;
      rst = 1'b1; #1;
      chk_cnt++;
      if (mem_req_valid !== 1'b0) $display("FAIL rst_mid_req: got mem_req_valid=%b expected 0", mem_req_valid); else pass_cnt++;
      @(negedge clk); rst = 1'b0; #1;
      chk_cnt++;
      if ({mem_req_valid, i_req_ready, d_req_ready, i_resp_valid, d_resp_valid} !== 5'b0 || mem_req_addr !== 32'h0)
         $display("FAIL after_rst: got flags=%b addr=%h expected 0", {mem_req_valid, i_req_ready, d_req_ready, i_resp_valid, d_resp_valid}, mem_req_addr);
      else pass_cnt++;
      mem_resp_valid = 1'b1; mem_resp_rdata = 32'h77;
      d_req_valid = 1'b1; d_req_addr = 32'h0000_0800; #1;
      chk_cnt++;
      if (d_req_ready !== 1'b1) $display("FAIL idle_after_rst: got d_req_ready=%b expected 1", d_req_ready); else pass_cnt++;
      d_req_valid = 1'b0;
      @(negedge clk); mem_resp_valid = 1'b0; #1;
      chk_cnt++;
      if ({i_resp_valid, d_resp_valid, mem_req_valid} !== 3'b0 || i_resp_rdata !== 32'h0 || d_resp_rdata !== 32'h0)
         $display("FAIL late_resp_and_drop: got flags=%b i=%h d=%h expected 0", {i_resp_valid, d_resp_valid, mem_req_valid}, i_resp_rdata, d_resp_rdata);
      else pass_cnt++;
   endtask

   task automatic test_i_only();
      bit p; logic [31:0] e;
      @(negedge clk); i_req_valid = 1'b1; i_req_addr = 32'h0000_0100; #1;
      chk_cnt++;
      if (i_req_ready !== 1'b1 || d_req_ready !== 1'b0) $display("FAIL i_accept: got i=%b d=%b expected 1/0", i_req_ready, d_req_ready);
      else pass_cnt++;
      exp_port_q.push_back(1'b0); exp_data_q.push_back(32'h0000_0013);
      @(negedge clk); i_req_valid = 1'b0; i_req_addr = 32'h0; #1;
      chk_cnt++;
      if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h100 || mem_req_wen !== 1'b0 || mem_req_wdata !== 32'h0 ||
          mem_req_wmask !== 4'h0 || i_req_ready !== 1'b0)
         $display("FAIL i_mem_req: got v=%b a=%h w=%b d=%h m=%h", mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wmask);
      else pass_cnt++;
      mem_req_ready = 1'b1;
      @(negedge clk); mem_req_ready = 1'b0; mem_resp_valid = 1'b1; mem_resp_rdata = 32'h0000_0013; #1;
      chk_cnt++;
      if (mem_req_valid !== 1'b0 || i_resp_valid !== 1'b0) $display("FAIL i_wait_resp: got req=%b resp=%b expected 0/0", mem_req_valid, i_resp_valid);
      else pass_cnt++;
      @(negedge clk); mem_resp_valid = 1'b0; mem_resp_rdata = 32'h0; #1;
      chk_cnt++;
      if (i_resp_valid !== 1'b1 || d_resp_valid !== 1'b0) $display("FAIL i_pulse: got i=%b d=%b expected 1/0", i_resp_valid, d_resp_valid);
      else pass_cnt++;
      if (exp_port_q.size() > 0) begin
         p = exp_port_q.pop_front(); e = exp_data_q.pop_front(); hold_i = e;
         chk_cnt++;
         if (p !== 1'b0 || i_resp_rdata !== e) $display("FAIL i_rdata: got %h expected %h", i_resp_rdata, e); else pass_cnt++;
      end
      @(negedge clk); #1;
      chk_cnt++;
      if (i_resp_valid !== 1'b0 || i_resp_rdata !== hold_i) $display("FAIL i_pulse_end: got v=%b d=%h expected 0/%h", i_resp_valid, i_resp_rdata, hold_i);
      else pass_cnt++;
   endtask

   task automatic test_d_store();
      bit p; logic [31:0] e; int d_pulses = 0; int i_pulses = 0;
      @(negedge clk); d_req_valid = 1'b1; d_req_addr = 32'h0000_2000; d_req_wen = 1'b1;
      d_req_wdata = 32'hDEAD_BEEF; d_req_wmask = 4'hF; #1;
      chk_cnt++;
      if (d_req_ready !== 1'b1 || i_req_ready !== 1'b0) $display("FAIL d_accept: got d=%b i=%b expected 1/0", d_req_ready, i_req_ready);
      else pass_cnt++;
      exp_port_q.push_back(1'b1); exp_data_q.push_back(32'h0);
      @(negedge clk); d_req_valid = 1'b0; d_req_wen = 1'b0; #1;
      chk_cnt++;
      if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h2000 || mem_req_wen !== 1'b1 ||
          mem_req_wdata !== 32'hDEAD_BEEF || mem_req_wmask !== 4'hF)
         $display("FAIL d_mem_req: got v=%b a=%h w=%b d=%h m=%h", mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wmask);
      else pass_cnt++;
      mem_req_ready = 1'b1;
      @(negedge clk); mem_req_ready = 1'b0; mem_resp_valid = 1'b1; mem_resp_rdata = 32'h0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk); mem_resp_valid = 1'b0; #1;
         if (i_resp_valid === 1'b1) i_pulses++;
         if (d_resp_valid === 1'b1) begin
            d_pulses++;
            if (exp_port_q.size() > 0) begin
               p = exp_port_q.pop_front(); e = exp_data_q.pop_front(); hold_d = e;
               chk_cnt++;
               if (p !== 1'b1 || d_resp_rdata !== e) $display("FAIL d_store_resp: got %h expected %h", d_resp_rdata, e); else pass_cnt++;
            end
         end
      end
      chk_cnt++;
      if (d_pulses != 1 || i_pulses != 0 || i_resp_rdata !== hold_i)
         $display("FAIL d_store_pulses: got d=%0d i=%0d expected 1/0", d_pulses, i_pulses);
      else pass_cnt++;
   endtask

   task automatic test_contention();
      bit exp_grant[$]; bit g; bit p; logic [31:0] e;
      int accepts = 0; int resps = 0; int n_i = 0; int n_d = 0; int accept_cyc = 0;
      apply_reset();
`ifdef MEMARB_ROUND_ROBIN_EN
      exp_grant = '{1'b1, 1'b0, 1'b1, 1'b0};
`else
      exp_grant = '{1'b1, 1'b1, 1'b1, 1'b1};
`endif
      mem_ready_en = 1'b1;
      d_req_wen = 1'b0; d_req_wdata = 32'h0; d_req_wmask = 4'h0;
      for (int cyc = 0; cyc < 100 && resps < 4; cyc++) begin
         @(negedge clk);
         mem_pre();
         i_req_valid = (accepts < 4); d_req_valid = (accepts < 4);
         i_req_addr = 32'h0000_1000 + 32'(n_i) * 32'd4;
         d_req_addr = 32'h0000_3000 + 32'(n_d) * 32'd4;
         #1;
         if (i_resp_valid === 1'b1 || d_resp_valid === 1'b1) begin
            resps++;
            chk_cnt++;
            if (cyc - accept_cyc != 3) $display("FAIL latency: got %0d expected 3", cyc - accept_cyc); else pass_cnt++;
            if (exp_port_q.size() > 0) begin
               p = exp_port_q.pop_front(); e = exp_data_q.pop_front();
               chk_cnt++;
               if (p) begin
                  hold_d = e;
                  if (d_resp_valid !== 1'b1 || i_resp_valid !== 1'b0 || d_resp_rdata !== e)
                     $display("FAIL cont_resp_d: got %h expected %h", d_resp_rdata, e);
                  else pass_cnt++;
               end else begin
                  hold_i = e;
                  if (i_resp_valid !== 1'b1 || d_resp_valid !== 1'b0 || i_resp_rdata !== e)
                     $display("FAIL cont_resp_i: got %h expected %h", i_resp_rdata, e);
                  else pass_cnt++;
               end
            end
            if (accepts < 4) begin
               chk_cnt++;
               if (i_req_ready !== 1'b1 && d_req_ready !== 1'b1) $display("FAIL back_to_back: got no ready in pulse cycle expected one");
               else pass_cnt++;
            end
         end
         if (i_req_ready === 1'b1 || d_req_ready === 1'b1) begin
            g = (exp_grant.size() > 0) ? exp_grant.pop_front() : 1'b0;
            chk_cnt++;
            if (d_req_ready !== g || i_req_ready !== ~g) $display("FAIL grant_%0d: got d=%b i=%b expected d=%b", accepts, d_req_ready, i_req_ready, g);
            else pass_cnt++;
            exp_port_q.push_back(d_req_ready);
            exp_data_q.push_back((d_req_ready ? d_req_addr : i_req_addr) ^ K);
            if (d_req_ready) n_d++; else n_i++;
            accepts++; accept_cyc = cyc;
         end
         mem_post();
      end
      chk_cnt++;
      if (accepts != 4 || resps != 4) $display("FAIL cont_timeout: got acc=%0d resp=%0d expected 4/4", accepts, resps); else pass_cnt++;
      i_req_valid = 1'b0; d_req_valid = 1'b0;
   endtask

   task automatic test_backpressure();
      bit p; logic [31:0] e; bit got = 1'b0;
      @(negedge clk); mem_pre(); mem_ready_en = 1'b0;
      d_req_valid = 1'b1; d_req_addr = 32'h0000_4000; d_req_wen = 1'b1; d_req_wdata = 32'hCAFE_F00D; d_req_wmask = 4'h3; #1;
      chk_cnt++;
      if (d_req_ready !== 1'b1) $display("FAIL bp_accept: got %b expected 1", d_req_ready); else pass_cnt++;
      exp_port_q.push_back(1'b1); exp_data_q.push_back(32'h0000_4000 ^ K);
      mem_post();
      for (int i = 0; i < 5; i++) begin
         @(negedge clk); mem_pre(); d_req_valid = 1'b0;
         d_req_addr = 32'h0000_5000 + 32'(i); d_req_wdata = $urandom; d_req_wmask = 4'(i); #1;
         chk_cnt++;
         if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h4000 || mem_req_wen !== 1'b1 ||
             mem_req_wdata !== 32'hCAFE_F00D || mem_req_wmask !== 4'h3 || d_req_ready !== 1'b0)
            $display("FAIL bp_stable_%0d: got v=%b a=%h d=%h m=%h", i, mem_req_valid, mem_req_addr, mem_req_wdata, mem_req_wmask);
         else pass_cnt++;
         mem_post();
      end
      mem_ready_en = 1'b1;
      for (int i = 0; i < 10 && !got; i++) begin
         @(negedge clk); mem_pre(); #1;
         if (d_resp_valid === 1'b1 && exp_port_q.size() > 0) begin
            got = 1'b1;
            p = exp_port_q.pop_front(); e = exp_data_q.pop_front(); hold_d = e;
            chk_cnt++;
            if (p !== 1'b1 || d_resp_rdata !== e || i_resp_valid !== 1'b0) $display("FAIL bp_resp: got %h expected %h", d_resp_rdata, e);
            else pass_cnt++;
         end
         mem_post();
      end
      chk_cnt++;
      if (!got) $display("FAIL bp_timeout: got no d_resp_valid expected one"); else pass_cnt++;
      mem_ready_en = 1'b0; mem_req_ready = 1'b0;
   endtask

   task automatic test_spurious();
      @(negedge clk); mem_resp_valid = 1'b1; mem_resp_rdata = 32'h0000_0055;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk); mem_resp_valid = 1'b0; #1;
         chk_cnt++;
         if ({i_resp_valid, d_resp_valid, mem_req_valid} !== 3'b0 || i_resp_rdata !== hold_i || d_resp_rdata !== hold_d)
            $display("FAIL spurious_%0d: got v=%b i=%h d=%h expected 0 %h %h", i, {i_resp_valid, d_resp_valid}, i_resp_rdata, d_resp_rdata, hold_i, hold_d);
         else pass_cnt++;
      end
   endtask

   initial begin
      rst = 1'b1;
      i_req_valid = 1'b0; i_req_addr = 32'h0;
      d_req_valid = 1'b0; d_req_addr = 32'h0; d_req_wen = 1'b0; d_req_wdata = 32'h0; d_req_wmask = 4'h0;
      mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_rdata = 32'h0;
      resp_due = 1'b0; resp_due_data = 32'h0; mem_ready_en = 1'b0; hold_i = 32'h0; hold_d = 32'h0;
      test_reset();
      test_i_only();
      test_d_store();
      test_contention();
      test_backpressure();
      test_spurious();
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1);
   end
endmodule
